// File: rtl/vga_fb_scheduler_pkg.sv
// Shared constants and types for the VGA framebuffer scheduler.
package vga_pkg;

  // Default visible raster size.
  localparam int H_ACTIVE_DEF = 640;
  localparam int V_ACTIVE_DEF = 480;

  // Framebuffer word holds one {R,G,B} pixel.
  localparam int COLOR_W = 24;

  // Scheduler state: wait for the first start-of-frame, then scan out.
  typedef enum logic {
    SYNC_WAIT = 1'b0,
    RUN       = 1'b1
  } state_e;

endpackage

// File: rtl/vga_fb_scheduler_pix_pipe.sv
// Two-stage pixel return pipe: stage 1 remembers what kind of slot was
// issued while the RAM produces data, stage 2 registers the DAC colour.
module vga_pix_pipe
  import vga_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               pix_en,
  input  logic               rd_issue,
  input  logic               last,
  input  logic [COLOR_W-1:0] mem_rdata,
  output logic [7:0]         R,
  output logic [7:0]         G,
  output logic [7:0]         B,
  output logic               frame_done
);

  logic               s1_valid_q;
  logic               s1_rd_q;
  logic               s1_last_q;
  logic [COLOR_W-1:0] rgb_q;
  logic [COLOR_W-1:0] rgb_d;
  logic               frame_done_q;

  // Next colour: fetched word for a real read, black for blank or unsynced slots.
  always_comb begin
    rgb_d = rgb_q;
    if (s1_valid_q) begin
      rgb_d = s1_rd_q ? mem_rdata : '0;
    end
  end

  // Pipe registers; colour holds between pixel strobes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid_q   <= 1'b0;
      s1_rd_q      <= 1'b0;
      s1_last_q    <= 1'b0;
      rgb_q        <= '0;
      frame_done_q <= 1'b0;
    end else begin
      s1_valid_q   <= pix_en;
      s1_rd_q      <= rd_issue;
      s1_last_q    <= last;
      rgb_q        <= rgb_d;
      frame_done_q <= s1_valid_q && s1_last_q;
    end
  end

  assign R          = rgb_q[23:16];
  assign G          = rgb_q[15:8];
  assign B          = rgb_q[7:0];
  assign frame_done = frame_done_q;

endmodule

// File: rtl/vga_fb_scheduler.sv
// Time-shares a single-port framebuffer RAM between VGA scanout reads
// (one per active pixel strobe) and a valid/ready drawing writer.
module vga_fb_scheduler
  import vga_pkg::*;
#(
  parameter int N        = 15,
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int ADDR_W   = 19
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               pix_en,
  input  logic [N:0]         horiz_count,
  input  logic [N:0]         vert_count,
  input  logic               wr_valid,
  input  logic [ADDR_W-1:0]  wr_addr,
  input  logic [COLOR_W-1:0] wr_data,
  output logic               wr_ready,
  output logic               mem_en,
  output logic               mem_we,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [COLOR_W-1:0] mem_wdata,
  input  logic [COLOR_W-1:0] mem_rdata,
  output logic [7:0]         R,
  output logic [7:0]         G,
  output logic [7:0]         B,
  output logic               frame_done
);

  localparam logic [N:0]        H_LIM    = (N+1)'(H_ACTIVE);
  localparam logic [N:0]        V_LIM    = (N+1)'(V_ACTIVE);
  localparam logic [N:0]        H_LAST   = (N+1)'(H_ACTIVE - 1);
  localparam logic [N:0]        V_LAST   = (N+1)'(V_ACTIVE - 1);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  state_e              state_q;
  logic [ADDR_W-1:0]   disp_addr_q;
  logic [ADDR_W-1:0]   disp_addr_d;
  logic [ADDR_W-1:0]   rd_addr;
  logic                active;
  logic                sof;
  logic                disp_slot;
  logic                last_pix;

  // Slot arbitration: display read wins on an active strobe, writer gets the rest.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path infers a latch.
    active    = (horiz_count < H_LIM) && (vert_count < V_LIM);
    sof       = pix_en && (horiz_count == '0) && (vert_count == '0);
    disp_slot = !reset && pix_en && active && ((state_q == RUN) || sof);
    last_pix  = disp_slot && (horiz_count == H_LAST) && (vert_count == V_LAST);
    // Start of frame reloads the address before the read so frames never drift.
    rd_addr     = sof ? '0 : disp_addr_q;
    disp_addr_d = rd_addr + ADDR_ONE;

    wr_ready  = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (disp_slot) begin
      mem_en   = 1'b1;
      mem_addr = rd_addr;
    end else if (!reset) begin
      wr_ready = 1'b1;
      if (wr_valid) begin
        mem_en    = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = wr_addr;
        mem_wdata = wr_data;
      end
    end
  end

  // Frame sync state and display address counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= SYNC_WAIT;
      disp_addr_q <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every register updating from pre-edge values.
      if (sof) begin
        state_q <= RUN;
      end
      if (disp_slot) begin
        disp_addr_q <= disp_addr_d;
      end
    end
  end

  vga_pix_pipe u_pix_pipe (
    .clk        (clk),
    .reset      (reset),
    .pix_en     (pix_en),
    .rd_issue   (disp_slot),
    .last       (last_pix),
    .mem_rdata  (mem_rdata),
    .R          (R),
    .G          (G),
    .B          (B),
    .frame_done (frame_done)
  );

endmodule

// File: tb/tb_vga_fb_scheduler.sv
// Scoreboard bench for vga_fb_scheduler on a reduced 32x12 raster
// (40x14 total) with a behavioural single-port RAM preloaded word k = k.
module tb_vga_fb_scheduler;

  localparam int N  = 15;
  localparam int H  = 32;
  localparam int V  = 12;
  localparam int HT = 40;
  localparam int VT = 14;
  localparam int AW = 11;
  localparam int STREAM_BASE = 1024;

  logic          clk = 1'b0;
  logic          reset;
  logic          pix_en;
  logic [N:0]    horiz_count;
  logic [N:0]    vert_count;
  logic          wr_valid;
  logic [AW-1:0] wr_addr;
  logic [23:0]   wr_data;
  logic          wr_ready;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [23:0]   mem_wdata;
  logic [23:0]   mem_rdata;
  logic [7:0]    R;
  logic [7:0]    G;
  logic [7:0]    B;
  logic          frame_done;

  always #5 clk = ~clk;

  vga_fb_scheduler #(
    .N        (N),
    .H_ACTIVE (H),
    .V_ACTIVE (V),
    .ADDR_W   (AW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .pix_en      (pix_en),
    .horiz_count (horiz_count),
    .vert_count  (vert_count),
    .wr_valid    (wr_valid),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .wr_ready    (wr_ready),
    .mem_en      (mem_en),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .R           (R),
    .G           (G),
    .B           (B),
    .frame_done  (frame_done)
  );

  // Behavioural synchronous single-port RAM with per-address write counters.
  logic [23:0] ram  [0:2047];
  int          hits [0:2047];
  logic [23:0] rdata_q;
  assign mem_rdata = rdata_q;

  initial begin
    rdata_q = '0;
    for (int k = 0; k < 2048; k++) begin
      ram[k]  = 24'(k);
      hits[k] = 0;
    end
  end

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        ram[mem_addr]  <= mem_wdata;
        hits[mem_addr] <= hits[mem_addr] + 1;
      end else begin
        rdata_q <= ram[mem_addr];
      end
    end
  end

  // Scoreboard entries.
  typedef struct {
    logic        rst;
    logic        disp;
    int          raddr;
    logic        wr;
    int          waddr;
    logic [23:0] wdata;
  } comb_exp_t;

  typedef struct {
    int          due;
    logic [23:0] rgb;
    logic        fd;
  } pix_exp_t;

  comb_exp_t comb_q[$];
  pix_exp_t  pix_q[$];

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int fd_count    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pops one bus expectation per cycle and any pixel result due now.
  always @(negedge clk) begin
    comb_exp_t c;
    pix_exp_t  p;
    if (frame_done === 1'b1) fd_count++;
    if (comb_q.size() > 0) begin
      c = comb_q.pop_front();
      if (c.rst) begin
        check("rst_mem_en", 32'(mem_en), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        check("rst_wr_ready", 32'(wr_ready), 32'd0);
        check("rst_rgb", 32'({R, G, B}), 32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);
      end else begin
        check("mem_en", 32'(mem_en), 32'(c.disp || c.wr));
        check("mem_we", 32'(mem_we), 32'(c.wr));
        check("wr_ready", 32'(wr_ready), 32'(!c.disp));
        if (c.disp) check("rd_addr", 32'(mem_addr), 32'(c.raddr));
        if (c.wr) begin
          check("wr_addr", 32'(mem_addr), 32'(c.waddr));
          check("wr_data", 32'(mem_wdata), 32'(c.wdata));
        end
        while (pix_q.size() > 0 && pix_q[0].due < cyc) begin
          p = pix_q.pop_front();
          check("pix_due", 32'(cyc), 32'(p.due));
        end
        if (pix_q.size() > 0 && pix_q[0].due == cyc) begin
          p = pix_q.pop_front();
          check("rgb", 32'({R, G, B}), 32'(p.rgb));
          check("frame_done", 32'(frame_done), 32'(p.fd));
        end else begin
          check("frame_done_idle", 32'(frame_done), 32'd0);
        end
      end
    end
  end

  // Stimulus state.
  int          hc;
  int          vc;
  int          frame;
  logic        synced;
  logic        wr_on;
  logic        wr_cont;
  logic [AW-1:0] cur_addr;
  logic [23:0] cur_data;
  int          n_stream = 0;
  int          n_dir    = 0;

  // One clk cycle: drive inputs, push expectations, follow the handshake.
  task automatic cycle(input logic pe);
    logic act;
    logic sof;
    logic disp;
    logic acc;
    pix_en      = pe;
    horiz_count = (N+1)'(hc);
    vert_count  = (N+1)'(vc);
    wr_valid    = wr_on;
    wr_addr     = cur_addr;
    wr_data     = cur_data;
    act = (hc < H) && (vc < V);
    sof = pe && (hc == 0) && (vc == 0);
    if (reset) synced = 1'b0;
    else if (sof) synced = 1'b1;
    disp = !reset && synced && pe && act;
    comb_q.push_back('{reset, disp, vc * H + hc, wr_on && !disp && !reset,
                       int'(cur_addr), cur_data});
    if (pe && !reset)
      pix_q.push_back('{cyc + 2, disp ? 24'(vc * H + hc) : 24'h0,
                        disp && (hc == H - 1) && (vc == V - 1)});
    @(negedge clk);
    acc = wr_valid && wr_ready;
    @(posedge clk);
    #1;
    if (acc) begin
      if (int'(cur_addr) >= STREAM_BASE) n_stream++;
      else n_dir++;
      if (wr_cont) begin
        cur_addr = cur_addr + 1'b1;
        cur_data = cur_data + 1'b1;
      end else begin
        wr_on = 1'b0;
      end
    end
  endtask

  // One pixel slot (strobe cycle plus gap cycle), then advance the counters.
  task automatic pixel();
    cycle(1'b1);
    cycle(1'b0);
    hc++;
    if (hc == HT) begin
      hc = 0;
      vc++;
      if (vc == VT) begin
        vc = 0;
        frame++;
      end
    end
  endtask

  initial begin
    reset = 1'b1; pix_en = 1'b0; horiz_count = '0; vert_count = '0;
    wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
    hc = 20; vc = 5; frame = 0; synced = 1'b0;
    wr_on = 1'b0; wr_cont = 1'b0; cur_addr = '0; cur_data = '0;
    @(posedge clk);
    #1;
    repeat (3) pixel();
    reset = 1'b0;

    // Frame 0 unsynced tail, frames 1-3, then the first lines of frame 4.
    while (frame < 4 || vc < 2) begin
      if (frame == 1 && hc == 10 && vc == 10) begin
        wr_on = 1'b1; wr_cont = 1'b0; cur_addr = AW'(900); cur_data = 24'h123456;
      end
      if (frame == 2 && hc == 0 && vc == 0) begin
        wr_on = 1'b1; wr_cont = 1'b1; cur_addr = AW'(STREAM_BASE); cur_data = 24'hA00000;
      end
      if (frame == 3 && hc == 0 && vc == 0) wr_cont = 1'b0;
      if (frame == 3 && hc == 16 && vc == 6) begin
        reset = 1'b1;
        pix_q.delete();
        pixel();
        reset = 1'b0;
      end else begin
        pixel();
      end
    end
    repeat (4) cycle(1'b0);

    check("pix_q_drained", 32'(pix_q.size()), 32'd0);
    check("frame_done_count", 32'(fd_count), 32'd2);
    check("dir_write_count", 32'(n_dir), 32'd1);
    check("dir_write_data", 32'(ram[900]), 32'h123456);
    check("dir_write_hits", 32'(hits[900]), 32'd1);
    check("stream_write_count", 32'(n_stream), 32'd737);
    for (int i = 0; i < n_stream; i++) begin
      check("stream_data", 32'(ram[STREAM_BASE + i]), 32'(24'hA00000 + 24'(i)));
      check("stream_hits", 32'(hits[STREAM_BASE + i]), 32'd1);
    end
    check("stream_no_extra", 32'(hits[STREAM_BASE + n_stream]), 32'd0);
    for (int k = 0; k < H * V; k++) begin
      check("display_region", 32'(ram[k]), 32'(k));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got cycle %0d, required finish", cyc);
    $fatal(1);
  end

endmodule
